// File: rtl/ti_share_splitter.sv
// Splits an unmasked nibble stream into NUM_SHARES Boolean shares using LFSR randomness.
// The output register isolates the shares from the unmasked input; valid/ready on both sides.
module ti_share_splitter #(
  parameter int          WIDTH      = 4,
  parameter int          NUM_SHARES = 2,
  parameter logic [15:0] SEED_RESET = 16'hACE1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          seed_load,
  input  logic [15:0]                   seed,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_SHARES*WIDTH-1:0]   out_shares,
  output logic [15:0]                   xfer_count
);

  localparam int MASK_W = (NUM_SHARES - 1) * WIDTH;

  if (NUM_SHARES < 2 || MASK_W > 16 || SEED_RESET == 16'h0000) begin : g_bad_params
    $error("ti_share_splitter: illegal parameter combination");
  end

  logic [15:0]                 lfsr;
  logic [15:0]                 lfsr_next;
  logic                        feedback;
  logic                        accept;
  logic [NUM_SHARES*WIDTH-1:0] shares_next;

  assign in_ready  = !seed_load && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign feedback  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign lfsr_next = {lfsr[14:0], feedback};

  // Mask shares come straight from the pre-advance LFSR; the last share absorbs the data.
  always_comb begin
    logic [WIDTH-1:0] last_share;
    shares_next = '0;
    last_share  = in_data;
    for (int i = 0; i < NUM_SHARES - 1; i++) begin
      shares_next[WIDTH*i +: WIDTH] = lfsr[WIDTH*i +: WIDTH];
      last_share                    = last_share ^ lfsr[WIDTH*i +: WIDTH];
    end
    shares_next[WIDTH*(NUM_SHARES-1) +: WIDTH] = last_share;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED_RESET;
      out_valid  <= 1'b0;
      out_shares <= '0;
      xfer_count <= '0;
    end else begin
      // The all-zero state would lock the LFSR, so a zero seed is replaced by 1.
      if (seed_load) begin
        lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
      end else if (accept) begin
        lfsr <= lfsr_next;
      end

      if (accept) begin
        out_shares <= shares_next;
        out_valid  <= 1'b1;
        xfer_count <= xfer_count + 16'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ti_share_splitter.sv
// Self-checking bench for ti_share_splitter: directed vector table, reference-model
// random traffic, and a full-rate 256-nibble stream.
module tb_ti_share_splitter;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_data = 4'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_shares;
  logic [15:0] xfer_count;

  ti_share_splitter #(.WIDTH(4), .NUM_SHARES(2), .SEED_RESET(SEED)) dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_shares(out_shares),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic        sl;
    logic [15:0] sd;
    logic        iv;
    logic [3:0]  id;
    logic        ordy;
    logic        e_ready;
    logic        e_valid;
    logic [7:0]  e_sh;
    logic [15:0] e_cnt;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [15:0] m_lfsr = SEED;
  logic        m_valid = 1'b0;
  logic [7:0]  m_sh = 8'h00;
  logic [15:0] m_cnt = 16'h0000;
  logic [3:0]  m_in = 4'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Maximal-length LFSR from taps 16,14,13,11 expressed as a parity of the tap mask.
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[14:0], ^(s & 16'hB400)};
  endfunction

  // Two-share split: mask is the low nibble of the LFSR, the other share hides the data.
  function automatic logic [7:0] split(input logic [15:0] s, input logic [3:0] d);
    logic [3:0] mask;
    mask = s[3:0];
    return {d ^ mask, mask};
  endfunction

  task automatic step(input vec_t v, input bit use_tbl);
    logic exp_ready;
    bit   acc;
    rst = v.rs; seed_load = v.sl; seed = v.sd;
    in_valid = v.iv; in_data = v.id; out_ready = v.ordy;
    #1;
    exp_ready = !v.sl && (!m_valid || v.ordy);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    if (use_tbl) chk("tbl_in_ready", {31'b0, in_ready}, {31'b0, v.e_ready});
    acc = v.iv && exp_ready;
    if (v.rs) begin
      m_valid = 1'b0; m_sh = 8'h00; m_cnt = 16'h0000; m_lfsr = SEED;
    end else begin
      if (acc) begin
        m_sh  = split(m_lfsr, v.id);
        m_in  = v.id;
        m_cnt = m_cnt + 16'd1;
      end
      if (v.sl) m_lfsr = (v.sd == 16'h0000) ? 16'h0001 : v.sd;
      else if (acc) m_lfsr = lfsr_adv(m_lfsr);
      if (acc) m_valid = 1'b1;
      else if (v.ordy) m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("xfer_count", {16'b0, xfer_count}, {16'b0, m_cnt});
    if (m_valid) begin
      chk("out_shares", {24'b0, out_shares}, {24'b0, m_sh});
      chk("share_xor", {28'b0, out_shares[7:4] ^ out_shares[3:0]}, {28'b0, m_in});
    end
    chk("lfsr", {16'b0, dut.lfsr}, {16'b0, m_lfsr});
    if (dut.lfsr == 16'h0000) begin
      errors++;
      $display("FAIL lfsr_nonzero: got 0 expected nonzero");
    end
    if (use_tbl) begin
      chk("tbl_out_valid", {31'b0, out_valid}, {31'b0, v.e_valid});
      chk("tbl_out_shares", {24'b0, out_shares}, {24'b0, v.e_sh});
      chk("tbl_xfer_count", {16'b0, xfer_count}, {16'b0, v.e_cnt});
    end
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    //                rs    sl    seed      iv    id    ordy  rdy   vld   shares  count
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 16'd0}); // reset
    tbl.push_back('{1'b0, 1'b1, 16'h0001, 1'b1, 4'hA, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0}); // seed load blocks input
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 8'hB1, 16'd1});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 8'hB1, 16'd1}); // backpressure
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 8'hB1, 16'd1});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'hA, 1'b0, 1'b0, 1'b1, 8'hB1, 16'd1});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 8'h82, 16'd2}); // drain+accept
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 8'h82, 16'd2});
    tbl.push_back('{1'b0, 1'b1, 16'h0000, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 8'h82, 16'd2}); // zero seed
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 8'h11, 16'd3});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'h5, 1'b0, 1'b0, 1'b1, 8'h11, 16'd3});
    tbl.push_back('{1'b1, 1'b0, 16'h0000, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 8'h00, 16'd0}); // reset mid-stream
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 16'd0});
    tbl.push_back('{1'b0, 1'b0, 16'h0000, 1'b1, 4'h3, 1'b1, 1'b1, 1'b1, 8'h21, 16'd1}); // SEED_RESET mask
    tbl.push_back('{1'b0, 1'b1, 16'h1234, 1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 8'h21, 16'd1}); // load while draining

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1);
    chk("lfsr_after_seed", {16'b0, dut.lfsr}, 32'h1234);

    // Random traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      v.rs   = ($urandom_range(0, 63) == 0);
      v.sl   = ($urandom_range(0, 15) == 0);
      v.sd   = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      v.iv   = $urandom_range(0, 3) != 0;
      v.id   = 4'($urandom);
      v.ordy = $urandom_range(0, 2) != 0;
      v.e_ready = 1'b0; v.e_valid = 1'b0; v.e_sh = 8'h00; v.e_cnt = 16'h0000;
      step(v, 1'b0);
    end

    // Full-rate stream of 256 nibbles after reset
    v = '{1'b1, 1'b0, 16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
    step(v, 1'b0);
    for (int i = 0; i < 256; i++) begin
      v = '{1'b0, 1'b0, 16'h0000, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 8'h00, 16'd0};
      step(v, 1'b0);
      chk("stream_valid", {31'b0, out_valid}, 32'd1);
    end
    chk("stream_count", {16'b0, xfer_count}, 32'd256);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ti_share_splitter.md
Name: ti_share_splitter

Overview:
- Upstream masking stage for the 4-bit threshold-implementation (TI) S-box datapath.
- Accepts an unmasked nibble stream and splits each nibble into NUM_SHARES Boolean shares using fresh LFSR randomness.
- Presents the packed shares as the 8-bit selector vector consumed by the TI component-function lookup blocks.
- Registered output with valid/ready handshake, so the shares are glitch-isolated from the unmasked input.

Parameters:
- WIDTH, 4, bits per share (S-box width).
- NUM_SHARES, 2, number of output shares. Legal when (NUM_SHARES-1)*WIDTH <= 16 and NUM_SHARES >= 2.
- SEED_RESET, 16'hACE1, LFSR value after reset. Must be nonzero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- seed_load  in  1  load LFSR from seed this cycle.
- seed  in  16  LFSR seed value.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  WIDTH  unmasked nibble.
- out_valid  out  1  out_shares valid.
- out_ready  in  1  downstream accepts out_shares.
- out_shares  out  NUM_SHARES*WIDTH  packed shares; share i at bits [WIDTH*i +: WIDTH].
- xfer_count  out  16  number of accepted input nibbles, wrapping.

Behaviour:
- Reset (rst=1 at clock edge): out_valid=0, out_shares=0, xfer_count=0, lfsr=SEED_RESET. rst overrides seed_load and all transfers.
- LFSR:
  - 16-bit Fibonacci, shifts left: lfsr_next = {lfsr[14:0], fb}, with fb = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10].
  - Advances exactly once per accepted input and never otherwise.
- Mask bits: mask = lfsr[(NUM_SHARES-1)*WIDTH-1:0], taken from the current (pre-advance) state.
- Shares:
  - share i = mask[WIDTH*i +: WIDTH] for i < NUM_SHARES-1.
  - Last share = in_data XOR all preceding shares.
  - The XOR of all shares always equals in_data.
- Handshake:
  - in_ready = !seed_load && (!out_valid || out_ready). This is combinational on out_ready; no combinational path from in_valid to in_ready.
  - An input is accepted when in_valid && in_ready. On acceptance, out_shares and out_valid=1 are registered at the next edge. Latency is 1 cycle.
  - If out_valid && !out_ready, out_shares is held stable and in_ready=0.
  - If out_valid && out_ready with no new accept, out_valid drops to 0. out_shares keeps its last value, which is don't-care.
  - Accept and drain in the same cycle: out_valid stays 1 and out_shares updates. This gives full throughput, 1 nibble per cycle.
- Seed load:
  - When seed_load=1 (and rst=0), lfsr <= seed. If seed==0, lfsr <= 16'h0001 instead, because the all-zero state is forbidden.
  - No input is accepted that cycle (in_ready=0). The output register and out_valid are unaffected, so a pending output may still drain.
- xfer_count: increments by 1 per accepted input and wraps 16'hFFFF -> 0.
- in_data is never registered unmasked and never appears on out_shares alone unless the mask is 0.
- Reset mid-stream: a pending output is discarded (out_valid=0 next cycle), with no partial state kept.

Test Plan:
- Reset then seed_load seed=16'h0001; with NUM_SHARES=2, send in_data=4'hA then 4'hA, out_ready=1 -> out_shares=8'hB1 then 8'h82. lfsr=16'h0004, xfer_count=2.
- Backpressure: out_ready=0 after the first accept, in_valid held high -> in_ready=0, out_shares held at 8'hB1 for N cycles, lfsr unchanged. Raise out_ready -> next nibble accepted the same cycle, no loss or duplication.
- Continuous stream of 256 nibbles with out_ready=1 -> one output per cycle. XOR of shares equals the input for every beat, and xfer_count=256.
- seed_load with seed=16'h0000 -> lfsr=16'h0001. in_ready=0 during the load cycle, and the next output with in_data=4'h0 equals 8'h11.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, xfer_count=0, lfsr=SEED_RESET, in_ready=1.
- Wrap: preload via 65536 accepts -> xfer_count returns to 0. LFSR never reaches 0 across the whole run.
